// File: rtl/tx_axis_arbiter.sv
// ---------------------------------------------------------------------------
// tx_axis_arbiter
//
// Packet-level round-robin arbiter that lets NUM_PORTS AXI-Stream sources
// share the single tx_mac input. Once a source is granted it owns the output
// until its tlast beat is accepted, so frames are never interleaved. The data
// path is a purely combinational mux (zero latency); only the arbitration
// state is registered.
//
// Parameters
//   NUM_PORTS   number of requesting sources (2..8)
//   DATA_WIDTH  AXI-Stream data width
//   MIN_GAP     extra idle cycles spent in IDLE after a frame (0..255)
//
// Ports
//   clk, reset_n     clock and synchronous active-low reset
//   s_axis_*         per-source slave streams; data of port i at [i*DW +: DW]
//   s_axis_trdy      per-source ready, only the granted port can see a 1
//   m_axis_*         merged master stream towards tx_mac
//   m_axis_trdy      ready from tx_mac
//   grant_id         index of the current (PASS) or last granted port
//   busy             high while a frame is being passed through
// ---------------------------------------------------------------------------
module tx_axis_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MIN_GAP    = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  input  logic [NUM_PORTS-1:0]            s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]            s_axis_tuser,
  output logic [NUM_PORTS-1:0]            s_axis_trdy,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tkeep,
  output logic                            m_axis_tuser,
  input  logic                            m_axis_trdy,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
  output logic                            busy
);

  localparam int GW = $clog2(NUM_PORTS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      gap_cnt_q, gap_cnt_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;

  logic [GW-1:0]   sel_port;
  logic            sel_found;
  logic            frame_done;

  // -------------------------------------------------------------------------
  // Round-robin selection: scan rr_ptr+1, rr_ptr+2, ... (mod NUM_PORTS) and
  // take the first port with tvalid set. The last granted port is scanned
  // last, which gives it the lowest priority for the next frame.
  // -------------------------------------------------------------------------
  always_comb begin : rr_select
    int idx;
    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    idx       = 0;
    sel_port  = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
      if (!sel_found && s_axis_tvalid[idx]) begin
        sel_port  = GW'(idx);
        sel_found = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Data path: combinational mux of the granted port while in PASS. Outside
  // PASS nothing is forwarded and no source sees ready, so no beat can be
  // accepted while arbitration is pending.
  // -------------------------------------------------------------------------
  always_comb begin : data_mux
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tkeep  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_trdy   = '0;
    if (state_q == ST_PASS) begin
      m_axis_tdata              = s_axis_tdata[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tvalid             = s_axis_tvalid[grant_id_q];
      m_axis_tlast              = s_axis_tlast[grant_id_q];
      m_axis_tkeep              = s_axis_tkeep[grant_id_q];
      m_axis_tuser              = s_axis_tuser[grant_id_q];
      s_axis_trdy[grant_id_q]   = m_axis_trdy;
    end
  end

  // The grant is released only by the accepted tlast beat; a source that
  // drops tvalid mid-frame keeps its grant. tuser does not end a frame.
  assign frame_done = (state_q == ST_PASS) && m_axis_tvalid && m_axis_trdy && m_axis_tlast;

  // -------------------------------------------------------------------------
  // Next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin : next_state
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gap_cnt_q != 8'd0) begin
          // Inter-frame gap still running; requests wait.
          gap_cnt_d = gap_cnt_q - 8'd1;
        end else if (sel_found) begin
          state_d    = ST_PASS;
          grant_id_d = sel_port;
          rr_ptr_d   = sel_port;
        end
      end
      ST_PASS: begin
        if (frame_done) begin
          // Leaving PASS always costs one IDLE cycle; MIN_GAP adds to that.
          state_d   = ST_IDLE;
          gap_cnt_d = 8'(MIN_GAP);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers. rr_ptr resets to the last port so that port 0 is the
  // first one scanned after reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of the others.
    if (!reset_n) begin
      // NOTE: reset is synchronous here (sampled on the clock edge), and a
      // frame in flight is simply dropped; tx_mac shares this reset.
      state_q    <= ST_IDLE;
      gap_cnt_q  <= 8'd0;
      rr_ptr_q   <= GW'(NUM_PORTS - 1);
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == ST_PASS);

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tx_axis_arbiter
//
// Self-checking bench for tx_axis_arbiter (NUM_PORTS=2, DATA_WIDTH=8).
// Two instances share all inputs: dut uses MIN_GAP=0, dut_gap uses
// MIN_GAP=12; use_gap selects which one the traffic driver observes.
// A directed vector table covers single-cycle behaviour; hand-written
// sequences cover multi-cycle corner cases (long frames, contention,
// backpressure, inter-frame gap, reset mid-frame).
// ---------------------------------------------------------------------------
module tb_tx_axis_arbiter;

  logic        clk;
  logic        reset_n;
  logic [15:0] s_tdata;
  logic [1:0]  s_tvalid, s_tlast, s_tkeep, s_tuser;
  logic        m_trdy;

  logic [1:0]  d_s_trdy, g_s_trdy;
  logic [7:0]  d_m_tdata, g_m_tdata;
  logic        d_m_tvalid, d_m_tlast, d_m_tkeep, d_m_tuser, d_grant, d_busy;
  logic        g_m_tvalid, g_m_tlast, g_m_tkeep, g_m_tuser, g_grant, g_busy;

  logic        use_gap;
  logic [1:0]  o_s_trdy;
  logic [7:0]  o_m_tdata;
  logic        o_m_tvalid, o_m_tlast, o_m_tkeep, o_m_tuser, o_grant, o_busy;

  int n_checks = 0;
  int n_errors = 0;

  tx_axis_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(8), .MIN_GAP(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser), .s_axis_trdy(d_s_trdy),
    .m_axis_tdata(d_m_tdata), .m_axis_tvalid(d_m_tvalid), .m_axis_tlast(d_m_tlast),
    .m_axis_tkeep(d_m_tkeep), .m_axis_tuser(d_m_tuser), .m_axis_trdy(m_trdy),
    .grant_id(d_grant), .busy(d_busy)
  );

  tx_axis_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(8), .MIN_GAP(12)) dut_gap (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser), .s_axis_trdy(g_s_trdy),
    .m_axis_tdata(g_m_tdata), .m_axis_tvalid(g_m_tvalid), .m_axis_tlast(g_m_tlast),
    .m_axis_tkeep(g_m_tkeep), .m_axis_tuser(g_m_tuser), .m_axis_trdy(m_trdy),
    .grant_id(g_grant), .busy(g_busy)
  );

  always_comb begin
    if (use_gap) begin
      o_s_trdy = g_s_trdy;  o_m_tdata = g_m_tdata; o_m_tvalid = g_m_tvalid;
      o_m_tlast = g_m_tlast; o_m_tkeep = g_m_tkeep; o_m_tuser = g_m_tuser;
      o_grant = g_grant;     o_busy = g_busy;
    end else begin
      o_s_trdy = d_s_trdy;  o_m_tdata = d_m_tdata; o_m_tvalid = d_m_tvalid;
      o_m_tlast = d_m_tlast; o_m_tkeep = d_m_tkeep; o_m_tuser = d_m_tuser;
      o_grant = d_grant;     o_busy = d_busy;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    s_tvalid = 2'b00; s_tlast = 2'b00; s_tkeep = 2'b11; s_tuser = 2'b00;
    s_tdata  = 16'h0000; m_trdy = 1'b1;
  endtask

  // Leaves the bench at posedge+1 with reset released and fresh DUT state.
  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [7:0] beat_byte(input int p, input int f, input int b);
    return 8'((p << 7) | ((f & 1) << 6) | (b & 63));
  endfunction

  // Expected grant order of the frames for run_traffic.
  int ord_q[$];

  // Both sources stream nfr frames of len bytes; the output stream is compared
  // against the concatenation of frames in the order given by ord_q.
  task automatic run_traffic(input string tag, input int len0, input int len1,
                             input int nfr0, input int nfr1, input bit toggle,
                             input int max_cyc, output int busy_cyc,
                             output int gap, output int lasts);
    logic [8:0] exp_q[$];
    int len[2], nfr[2], beat[2], fr[2], fcnt[2];
    int cyc, frame_idx, last_cyc, viol;
    bit first;
    logic [8:0] e;
    logic src_hs, m_hs;
    len = '{len0, len1}; nfr = '{nfr0, nfr1};
    beat = '{0, 0}; fr = '{0, 0}; fcnt = '{0, 0};
    foreach (ord_q[i]) begin
      for (int b = 0; b < len[ord_q[i]]; b++)
        exp_q.push_back({(b == len[ord_q[i]] - 1), beat_byte(ord_q[i], fcnt[ord_q[i]], b)});
      fcnt[ord_q[i]]++;
    end
    cyc = 0; frame_idx = 0; last_cyc = -1; viol = 0; first = 1'b1;
    busy_cyc = 0; gap = -1; lasts = 0;
    while (cyc < max_cyc && exp_q.size() > 0) begin
      for (int p = 0; p < 2; p++) begin
        s_tvalid[p]        = (fr[p] < nfr[p]);
        s_tdata[p*8 +: 8]  = beat_byte(p, fr[p], beat[p]);
        s_tlast[p]         = (beat[p] == len[p] - 1);
      end
      s_tkeep = 2'b11; s_tuser = 2'b00;
      m_trdy  = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (o_busy) busy_cyc++;
      if (o_m_tvalid && last_cyc >= 0 && gap < 0) gap = cyc - last_cyc - 1;
      if ((o_s_trdy != 2'b00) && !m_trdy) viol++;
      if (o_s_trdy == 2'b11) viol++;
      src_hs = ((s_tvalid & o_s_trdy) != 2'b00);
      m_hs   = o_m_tvalid && m_trdy;
      if (src_hs != m_hs) viol++;
      if (m_hs) begin
        e = exp_q.pop_front();
        check($sformatf("%s_byte", tag), 32'(o_m_tdata), 32'(e[7:0]));
        check($sformatf("%s_last", tag), 32'(o_m_tlast), 32'(e[8]));
        if (first && frame_idx < ord_q.size())
          check($sformatf("%s_grant%0d", tag, frame_idx), 32'(o_grant), 32'(ord_q[frame_idx]));
        first = 1'b0;
        if (o_m_tlast) begin
          lasts++; last_cyc = cyc; frame_idx++; first = 1'b1;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (s_tvalid[p] && o_s_trdy[p]) begin
          beat[p]++;
          if (beat[p] == len[p]) begin beat[p] = 0; fr[p]++; end
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    idle_inputs();
    check($sformatf("%s_remaining_beats", tag), 32'(exp_q.size()), 32'd0);
    check($sformatf("%s_protocol_violations", tag), 32'(viol), 32'd0);
  endtask

  typedef struct {
    logic        rst_n;
    logic [1:0]  vld, lst, kep, usr;
    logic [15:0] dat;
    logic        mrdy;
    logic        e_vld;
    logic [7:0]  e_dat;
    logic        e_lst, e_kep, e_usr;
    logic [1:0]  e_rdy;
    logic        e_busy, e_gnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int busy_cyc, gap, lasts, hs;

    // rst_n  vld    lst    kep    usr    dat        mrdy | e_vld e_dat  lst  kep  usr  rdy    busy gnt
    tbl[0]  = '{1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 16'hB0A0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'b11, 2'b00, 2'b11, 2'b01, 16'hB0A1, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 2'b10, 2'b00, 2'b11, 2'b00, 16'hB0A2, 1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 2'b11, 2'b01, 2'b11, 2'b00, 16'hB0A3, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 2'b11, 2'b01, 2'b11, 2'b00, 16'hB0A3, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 16'hB0A5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'b11, 2'b10, 2'b11, 2'b10, 16'hB6A6, 1'b1, 1'b1, 8'hB6, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 2'b10, 2'b00, 2'b11, 2'b00, 16'hB7A7, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 2'b11, 2'b10, 2'b01, 2'b00, 16'hB8A8, 1'b1, 1'b1, 8'hB8, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 2'b01, 2'b01, 2'b11, 2'b00, 16'h00AA, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 2'b01, 2'b01, 2'b10, 2'b00, 16'h00AB, 1'b1, 1'b1, 8'hAB, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 2'b11, 2'b00, 2'b11, 2'b00, 16'hB0A0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 2'b10, 2'b00, 2'b11, 2'b00, 16'hBE00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 2'b10, 2'b10, 2'b11, 2'b00, 16'hBF00, 1'b1, 1'b1, 8'hBF, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1};

    use_gap = 1'b0;
    reset_n = 1'b0;
    idle_inputs();

    // Reset held 3 cycles with every source requesting.
    @(posedge clk); #1;
    s_tvalid = 2'b11; s_tlast = 2'b11; s_tdata = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("reset%0d_trdy", i),   32'(d_s_trdy),   32'd0);
      check($sformatf("reset%0d_mvalid", i), 32'(d_m_tvalid), 32'd0);
      check($sformatf("reset%0d_busy", i),   32'(d_busy),     32'd0);
      check($sformatf("reset%0d_grant", i),  32'(d_grant),    32'd0);
      check($sformatf("reset%0d_mdata", i),  32'(d_m_tdata),  32'd0);
    end

    // Directed vector table.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      reset_n  = tbl[i].rst_n;
      s_tvalid = tbl[i].vld; s_tlast = tbl[i].lst; s_tkeep = tbl[i].kep;
      s_tuser  = tbl[i].usr; s_tdata = tbl[i].dat; m_trdy  = tbl[i].mrdy;
      @(negedge clk);
      check($sformatf("tbl%0d_mvalid", i), 32'(d_m_tvalid), 32'(tbl[i].e_vld));
      check($sformatf("tbl%0d_mdata", i),  32'(d_m_tdata),  32'(tbl[i].e_dat));
      check($sformatf("tbl%0d_mlast", i),  32'(d_m_tlast),  32'(tbl[i].e_lst));
      check($sformatf("tbl%0d_mkeep", i),  32'(d_m_tkeep),  32'(tbl[i].e_kep));
      check($sformatf("tbl%0d_muser", i),  32'(d_m_tuser),  32'(tbl[i].e_usr));
      check($sformatf("tbl%0d_strdy", i),  32'(d_s_trdy),   32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_busy", i),   32'(d_busy),     32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_grant", i),  32'(d_grant),    32'(tbl[i].e_gnt));
      @(posedge clk); #1;
    end

    // Single source, two 64-byte frames back to back: 64 busy cycles each,
    // one idle cycle between them.
    do_reset();
    ord_q = '{0, 0};
    run_traffic("single", 64, 64, 2, 0, 1'b0, 1000, busy_cyc, gap, lasts);
    check("single_busy_cycles", 32'(busy_cyc), 32'd128);
    check("single_gap",         32'(gap),      32'd1);
    check("single_lasts",       32'(lasts),    32'd2);

    // Contention: both ports always requesting, strict alternation 0,1,0,1.
    do_reset();
    ord_q = '{0, 1, 0, 1};
    run_traffic("contend", 16, 16, 2, 2, 1'b0, 1000, busy_cyc, gap, lasts);
    check("contend_busy_cycles", 32'(busy_cyc), 32'd64);
    check("contend_lasts",       32'(lasts),    32'd4);

    // Backpressure: m_axis_trdy toggles every cycle through 60-byte frames.
    do_reset();
    ord_q = '{0, 1};
    run_traffic("bp", 60, 60, 1, 1, 1'b1, 2000, busy_cyc, gap, lasts);
    check("bp_lasts", 32'(lasts), 32'd2);

    // MIN_GAP=12 instance: 13 cycles without tvalid between frames.
    use_gap = 1'b1;
    do_reset();
    ord_q = '{1, 1};
    run_traffic("gap", 8, 8, 0, 2, 1'b0, 500, busy_cyc, gap, lasts);
    check("gap_idle_cycles", 32'(gap),   32'd13);
    check("gap_lasts",       32'(lasts), 32'd2);
    use_gap = 1'b0;

    // Reset in the middle of a port 0 frame after 20 accepted bytes.
    do_reset();
    hs = 0;
    for (int c = 0; c < 100 && hs < 20; c++) begin
      s_tvalid = 2'b01; s_tlast = 2'b00; s_tdata = {8'h00, 8'(hs)}; m_trdy = 1'b1;
      @(negedge clk);
      if (d_m_tvalid && m_trdy) hs++;
      @(posedge clk); #1;
    end
    check("midrst_bytes_before", 32'(hs), 32'd20);
    reset_n = 1'b0; s_tvalid = 2'b11; s_tdata = 16'hC214;
    @(posedge clk); #1;
    reset_n = 1'b1; s_tvalid = 2'b10;
    @(negedge clk);
    check("midrst_trdy",   32'(d_s_trdy),   32'd0);
    check("midrst_mvalid", 32'(d_m_tvalid), 32'd0);
    check("midrst_busy",   32'(d_busy),     32'd0);
    check("midrst_grant",  32'(d_grant),    32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_p1_busy",  32'(d_busy),    32'd1);
    check("midrst_p1_grant", 32'(d_grant),   32'd1);
    check("midrst_p1_data",  32'(d_m_tdata), 32'h0000_00C2);
    check("midrst_p1_trdy",  32'(d_s_trdy),  32'd2);
    @(posedge clk); #1;
    // Reset again with both requesting: port 0 must win after release.
    reset_n = 1'b0; s_tvalid = 2'b11;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_both_grant", 32'(d_grant),  32'd0);
    check("midrst_both_busy",  32'(d_busy),   32'd1);
    check("midrst_both_trdy",  32'(d_s_trdy), 32'd1);
    @(posedge clk); #1;
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
